rsa_operand_loader: RTL and testbench

Deserialises the UART host byte stream into one complete RSA job: header fields, Montgomery operands xbar/mbar written word-wise into operand RAM, and exponent e plus modulus n presented as parallel registers.
It is the parametrised successor of the fixed 32-bit loader and supports arbitrary N (multiple of DBITS).
Adds a proper synchronous reset, a ready/valid handoff to the exponentiation core, rx backpressure, and an inter-byte timeout abort.
Sits between the UART receiver and the modexp controller / operand RAM.

---
 rtl/rsa_loader_pkg.sv | 20 ++
 rtl/rsa_operand_loader_packer.sv | 45 ++++
 rtl/rsa_operand_loader.sv | 146 ++++++++++++++
 tb/tb_rsa_operand_loader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_loader_pkg.sv
// Shared types and helpers for the RSA operand loader.
package rsa_loader_pkg;

  typedef enum logic [2:0] {
    S_MP,
    S_EIDX,
    S_XBAR,
    S_MBAR,
    S_E,
    S_N,
    S_DONE
  } state_t;

  localparam int HDR_BYTES = 2;

  function automatic int words_per_op(input int n, input int dbits);
    return n / dbits;
  endfunction

endpackage

// File: rtl/rsa_operand_loader_packer.sv
// Packs a byte stream into DBITS words, MSB first; flags each completed word
// with its ordinal within the current operand.
module byte_word_packer #(
  parameter int DBITS = 32,
  parameter int WORDS = 8,
  parameter int OW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [7:0]       i_byte,
  output logic             o_done,
  output logic [DBITS-1:0] o_word,
  output logic [OW-1:0]    o_ord
);
  localparam int BPW = DBITS / 8;
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [DBITS-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic [OW-1:0]    r_ord;

  // Truncating the concatenation keeps this valid for DBITS == 8 as well.
  assign o_word = DBITS'({r_acc, i_byte});
  assign o_done = i_en && (r_cnt == CW'(BPW - 1));
  assign o_ord  = r_ord;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ord <= '0;
    end else if (i_en) begin
      r_acc <= o_word;
      if (o_done) begin
        r_cnt <= '0;
        r_ord <= (r_ord == OW'(WORDS - 1)) ? '0 : r_ord + OW'(1);
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/rsa_operand_loader.sv
// Deserialises a UART byte stream into one RSA job: header, xbar/mbar into
// operand RAM, and e/n as parallel registers handed off via ready/valid.
module rsa_operand_loader
  import rsa_loader_pkg::*;
#(
  parameter int N         = 256,
  parameter int DBITS     = 32,
  parameter int ABITS     = 8,
  parameter int NLOG2     = 8,
  parameter int XBAR_BASE = 0,
  parameter int MBAR_BASE = N / DBITS,
  parameter int TIMEOUT   = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  output logic             rx_ready,
  input  logic [7:0]       rx_byte,
  output logic [NLOG2-1:0] tx_mp_count,
  output logic [NLOG2-1:0] tx_e_idx,
  output logic [N-1:0]     tx_e,
  output logic [N-1:0]     tx_n,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             wr_en,
  output logic [ABITS-1:0] wr_addr,
  output logic [DBITS-1:0] wr_data,
  output logic             err_timeout,
  output logic             busy
);
  localparam int W     = words_per_op(N, DBITS);
  localparam int BYTES = N / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int OW    = (W > 1) ? $clog2(W) : 1;
  localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t           r_state;
  logic [BCW-1:0]   r_bcnt;
  logic [TW-1:0]    r_idle;
  logic [NLOG2-1:0] r_mp, r_eidx;
  logic [N-1:0]     r_e, r_n;
  logic             r_tx_valid, r_wr_en, r_err;
  logic [ABITS-1:0] r_wr_addr;
  logic [DBITS-1:0] r_wr_data;

  logic             w_acc, w_last, w_op_state, w_busy, w_tmo, w_pk_en, w_pk_done;
  logic [DBITS-1:0] w_pk_word;
  logic [OW-1:0]    w_pk_ord;
  logic [ABITS-1:0] w_addr;
  int               w_base;

  assign rx_ready   = !rst && (r_state != S_DONE);
  assign w_acc      = rx_valid && rx_ready;
  assign w_busy     = (r_state != S_MP) && (r_state != S_DONE);
  assign w_last     = (r_bcnt == BCW'(BYTES - 1));
  assign w_op_state = (r_state == S_XBAR) || (r_state == S_MBAR) ||
                      (r_state == S_E) || (r_state == S_N);
  assign w_pk_en    = w_acc && ((r_state == S_XBAR) || (r_state == S_MBAR));
  // An accepted byte in the expiry cycle wins over the abort.
  assign w_tmo      = (TIMEOUT != 0) && w_busy && !w_acc && (r_idle == TW'(TIMEOUT - 1));

  byte_word_packer #(.DBITS(DBITS), .WORDS(W), .OW(OW)) u_packer (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_tmo),
    .i_en   (w_pk_en),
    .i_byte (rx_byte),
    .o_done (w_pk_done),
    .o_word (w_pk_word),
    .o_ord  (w_pk_ord)
  );

  // First word received is the most significant, so it lands at the top address.
  always_comb begin
    w_base = (r_state == S_XBAR) ? XBAR_BASE : MBAR_BASE;
    w_addr = ABITS'(w_base + W - 1 - int'(w_pk_ord));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_MP;
      r_bcnt     <= '0;
      r_idle     <= '0;
      r_mp       <= '0;
      r_eidx     <= '0;
      r_e        <= '0;
      r_n        <= '0;
      r_tx_valid <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_wr_en <= w_pk_done;
      r_err   <= w_tmo;
      if (w_pk_done) begin
        r_wr_addr <= w_addr;
        r_wr_data <= w_pk_word;
      end
      if (w_acc) begin
        r_idle <= '0;
        if (w_op_state) r_bcnt <= w_last ? '0 : r_bcnt + BCW'(1);
        case (r_state)
          S_MP:   begin r_mp <= rx_byte[NLOG2-1:0];   r_state <= S_EIDX; end
          S_EIDX: begin r_eidx <= rx_byte[NLOG2-1:0]; r_state <= S_XBAR; end
          S_XBAR: if (w_last) r_state <= S_MBAR;
          S_MBAR: if (w_last) r_state <= S_E;
          S_E: begin
            r_e <= N'({r_e, rx_byte});
            if (w_last) r_state <= S_N;
          end
          S_N: begin
            r_n <= N'({r_n, rx_byte});
            if (w_last) begin
              r_state    <= S_DONE;
              r_tx_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end else if (w_tmo) begin
        r_state <= S_MP;
        r_bcnt  <= '0;
        r_idle  <= '0;
      end else if (w_busy && TIMEOUT != 0) begin
        r_idle <= r_idle + TW'(1);
      end
      if (r_tx_valid && tx_ready) begin
        r_tx_valid <= 1'b0;
        r_state    <= S_MP;
      end
    end
  end

  assign tx_mp_count = r_mp;
  assign tx_e_idx    = r_eidx;
  assign tx_e        = r_e;
  assign tx_n        = r_n;
  assign tx_valid    = r_tx_valid;
  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign err_timeout = r_err;
  assign busy        = w_busy;

endmodule

// File: tb/tb_rsa_operand_loader.sv
// Bench for rsa_operand_loader: table-driven frames, timeout/reset sequences,
// random frames against a value-level model, and an N=256/DBITS=64 instance.
module tb_rsa_operand_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid, rx_ready, tx_ready, tx_valid, wr_en, err_timeout, busy;
  logic [7:0]  rx_byte, wr_addr;
  logic [5:0]  tx_mp_count, tx_e_idx;
  logic [63:0] tx_e, tx_n;
  logic [31:0] wr_data;

  logic         b_rx_valid, b_rx_ready, b_tx_valid, b_wr_en, b_err, b_busy;
  logic [7:0]   b_rx_byte, b_wr_addr, b_mp, b_eidx;
  logic [255:0] b_tx_e, b_tx_n;
  logic [63:0]  b_wr_data;

  always #5 clk = ~clk;

  rsa_operand_loader #(.N(64), .DBITS(32), .ABITS(8), .NLOG2(6), .XBAR_BASE(0),
                       .MBAR_BASE(2), .TIMEOUT(50)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_byte(rx_byte),
    .tx_mp_count(tx_mp_count), .tx_e_idx(tx_e_idx), .tx_e(tx_e), .tx_n(tx_n),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .err_timeout(err_timeout), .busy(busy));

  rsa_operand_loader #(.N(256), .DBITS(64), .ABITS(8), .NLOG2(8), .XBAR_BASE(0),
                       .MBAR_BASE(4), .TIMEOUT(50)) dut2 (
    .clk(clk), .rst(rst), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready), .rx_byte(b_rx_byte),
    .tx_mp_count(b_mp), .tx_e_idx(b_eidx), .tx_e(b_tx_e), .tx_n(b_tx_n),
    .tx_valid(b_tx_valid), .tx_ready(1'b1), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .err_timeout(b_err), .busy(b_busy));

  typedef struct packed { logic [7:0] a; logic [63:0] d; } wr_t;
  typedef struct {
    logic [7:0] mp, ei; logic [63:0] xb, mb, e, n; int gap, hold;
    logic [5:0] x_mp, x_ei; logic [31:0] a_all; logic [127:0] d_all; logic [63:0] x_e, x_n;
  } vec_t;

  wr_t wq[$];
  wr_t bq[$];
  int  err_pulses = 0;
  int  errors = 0, checks = 0;

  always @(negedge clk) begin
    if (wr_en)       wq.push_back('{a: wr_addr, d: 64'(wr_data)});
    if (b_wr_en)     bq.push_back('{a: b_wr_addr, d: b_wr_data});
    if (err_timeout) err_pulses++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected RAM image from operand values: word j = bits [j*32 +: 32] at base+j,
  // written most significant word first.
  function automatic vec_t model(input logic [7:0] mp, ei, input logic [63:0] xb, mb, e, n,
                                 input int gap, hold);
    vec_t v;
    v.mp = mp; v.ei = ei; v.xb = xb; v.mb = mb; v.e = e; v.n = n; v.gap = gap; v.hold = hold;
    v.x_mp = mp[5:0]; v.x_ei = ei[5:0]; v.x_e = e; v.x_n = n;
    v.a_all = {8'd1, 8'd0, 8'd3, 8'd2};
    v.d_all = {xb[63:32], xb[31:0], mb[63:32], mb[31:0]};
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    repeat (gap) begin @(posedge clk); #1; end
    while (!rx_ready && t < 100) begin @(posedge clk); #1; t++; end
    if (!rx_ready) chk("rx_ready_wait", rx_ready, 1);
    rx_valid = 1'b1; rx_byte = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_op(input logic [63:0] op, input int cnt, input int gap);
    logic [63:0] s = op;
    for (int i = 0; i < cnt; i++) begin
      send_byte(s[63:56], (gap > 0) ? int'($urandom_range(0, gap)) : 0);
      s = s << 8;
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int wb = wq.size();
    int eb = err_pulses;
    tx_ready = (v.hold == 0);
    send_byte(v.mp, 0);
    send_byte(v.ei, v.gap > 0 ? int'($urandom_range(0, v.gap)) : 0);
    send_op(v.xb, 8, v.gap); send_op(v.mb, 8, v.gap);
    send_op(v.e, 8, v.gap);  send_op(v.n, 8, v.gap);
    if (v.hold == 0) begin
      @(negedge clk);
      chk({tag, "_valid"}, tx_valid, 1);
      chk({tag, "_e"}, tx_e, v.x_e);
      chk({tag, "_n"}, tx_n, v.x_n);
      chk({tag, "_mp"}, tx_mp_count, v.x_mp);
      chk({tag, "_eidx"}, tx_e_idx, v.x_ei);
    end else begin
      for (int i = 0; i < v.hold; i++) begin
        @(negedge clk);
        chk({tag, "_hold_valid"}, tx_valid, 1);
        chk({tag, "_hold_rxrdy"}, rx_ready, 0);
        chk({tag, "_hold_e"}, tx_e, v.x_e);
        chk({tag, "_hold_n"}, tx_n, v.x_n);
      end
      chk({tag, "_mp"}, tx_mp_count, v.x_mp);
      chk({tag, "_eidx"}, tx_e_idx, v.x_ei);
      tx_ready = 1'b1;
    end
    @(negedge clk);
    chk({tag, "_valid_drop"}, tx_valid, 0);
    chk({tag, "_rxrdy_back"}, rx_ready, 1);
    chk({tag, "_nwrites"}, wq.size() - wb, 4);
    for (int i = 0; i < 4; i++) begin
      if (wb + i < wq.size()) begin
        chk({tag, "_waddr"}, wq[wb+i].a, v.a_all[31-8*i -: 8]);
        chk({tag, "_wdata"}, wq[wb+i].d, 64'(v.d_all[127-32*i -: 32]));
      end
    end
    chk({tag, "_no_tmo"}, err_pulses - eb, 0);
  endtask

  task automatic b_send(input logic [7:0] b);
    int t = 0;
    while (!b_rx_ready && t < 100) begin @(posedge clk); #1; t++; end
    if (!b_rx_ready) chk("b_rx_ready_wait", b_rx_ready, 1);
    b_rx_valid = 1'b1; b_rx_byte = b;
    @(posedge clk); #1;
    b_rx_valid = 1'b0;
  endtask

  vec_t tbl[3];

  initial begin
    tbl[0] = '{mp:8'h05, ei:8'h3F, xb:64'h0102030405060708, mb:64'h1112131415161718,
               e:64'h2122232425262728, n:64'h3132333435363738, gap:0, hold:0,
               x_mp:6'h05, x_ei:6'h3F, a_all:32'h01000302,
               d_all:128'h01020304_05060708_11121314_15161718,
               x_e:64'h2122232425262728, x_n:64'h3132333435363738};
    tbl[1] = tbl[0]; tbl[1].hold = 20;
    tbl[2] = tbl[0]; tbl[2].gap  = 10;

    rst = 1'b1; rx_valid = 1'b0; rx_byte = '0; tx_ready = 1'b1;
    b_rx_valid = 1'b0; b_rx_byte = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_e", tx_e, 0);
    chk("rst_err", err_timeout, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("idle_rx_ready", rx_ready, 1);

    for (int r = 0; r < 3; r++) run_vec($sformatf("tbl%0d", r), tbl[r]);

    // Timeout after 5 xbar bytes, then a clean frame.
    begin
      int eb = err_pulses;
      int hit = -1;
      send_byte(8'h05, 0); send_byte(8'h3F, 0); send_op(64'h0102030405060708, 5, 0);
      for (int i = 1; i <= 60; i++) begin
        @(negedge clk);
        if (err_timeout && hit < 0) hit = i;
      end
      chk("tmo_pulses", err_pulses - eb, 1);
      chk("tmo_cycle", hit, 51);
      chk("tmo_busy", busy, 0);
      run_vec("after_tmo", tbl[0]);
    end

    // Reset during mbar, then a new frame must decode from its first byte.
    send_byte(8'h05, 0); send_byte(8'h3F, 0);
    send_op(64'h0102030405060708, 8, 0); send_op(64'h1112131415161718, 4, 0);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("mrst_wr_en", wr_en, 0);
    chk("mrst_wr_addr", wr_addr, 0);
    chk("mrst_wr_data", wr_data, 0);
    chk("mrst_tx", {tx_e, tx_n, tx_mp_count, tx_e_idx}, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_valid", tx_valid, 0);
    run_vec("post_rst", model(8'h0A, 8'h12, 64'hA1A2A3A4A5A6A7A8, 64'hB1B2B3B4B5B6B7B8,
                              64'hC1C2C3C4C5C6C7C8, 64'hD1D2D3D4D5D6D7D8, 3, 0));

    for (int r = 0; r < 3; r++)
      run_vec($sformatf("rnd%0d", r),
              model(8'($urandom), 8'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                    {$urandom, $urandom}, {$urandom, $urandom}, 10, int'($urandom_range(0, 4))));

    // Wide instance: 4 words per operand.
    begin
      logic [255:0] xb, mb, e, n, s;
      logic [7:0] mp;
      int bb = bq.size();
      for (int i = 0; i < 8; i++) begin
        xb[32*i +: 32] = $urandom; mb[32*i +: 32] = $urandom;
        e[32*i +: 32]  = $urandom; n[32*i +: 32]  = $urandom;
      end
      mp = 8'($urandom);
      b_send(mp); b_send(8'h77);
      s = xb; for (int i = 0; i < 32; i++) begin b_send(s[255:248]); s = s << 8; end
      s = mb; for (int i = 0; i < 32; i++) begin b_send(s[255:248]); s = s << 8; end
      s = e;  for (int i = 0; i < 32; i++) begin b_send(s[255:248]); s = s << 8; end
      s = n;  for (int i = 0; i < 32; i++) begin b_send(s[255:248]); s = s << 8; end
      @(negedge clk);
      chk("w_valid", b_tx_valid, 1);
      chk("w_e", b_tx_e, e);
      chk("w_n", b_tx_n, n);
      chk("w_mp", b_mp, mp);
      chk("w_nwrites", bq.size() - bb, 8);
      for (int k = 0; k < 4; k++) begin
        if (bb + 4 + k < bq.size()) begin
          chk("w_x_addr", bq[bb+k].a, 3 - k);
          chk("w_x_data", bq[bb+k].d, xb[64*(3-k) +: 64]);
          chk("w_m_addr", bq[bb+4+k].a, 7 - k);
          chk("w_m_data", bq[bb+4+k].d, mb[64*(3-k) +: 64]);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
